// File: rtl/filt_pkg.sv
// Types, defaults and FSM encodings shared by the sample queue and the FIR filter blocks.
package filt_pkg;

    localparam int unsigned TAPS_DEF  = 1021;
    localparam int unsigned DEPTH_DEF = 1024;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t lft;
        sample_t rght;
    } stereo_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_SEQ   = 2'd2;

endpackage

// File: rtl/queue_ram.sv
// Simple dual-port sample store: one write port, one registered read port (1-cycle latency).
module queue_ram
    import filt_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  stereo_t       wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output stereo_t       rdata
);

    stereo_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_seq_queue.sv
// Circular stereo sample queue that replays the last TAPS pairs, oldest first, after each new sample.
// Optional feature: define OVERRUN_DET_EN to add the sticky overrun output.
module sample_seq_queue
    import filt_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned TAPS  = TAPS_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    valid,
    input  sample_t lft_in,
    input  sample_t rght_in,
    output logic    sequencing,
    output sample_t lft_out,
    output sample_t rght_out
`ifdef OVERRUN_DET_EN
    ,
    output logic    overrun
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(TAPS + 1);
    localparam int unsigned CW = $clog2(TAPS);

    localparam logic [AW-1:0] TAPS_A    = AW'(TAPS);
    localparam logic [FW-1:0] TAPS_F    = FW'(TAPS);
    localparam logic [CW-1:0] LAST_SLOT = CW'(TAPS - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [CW-1:0] slot_q, slot_d;
    logic          seq_q, seq_d;
    stereo_t       out_q, out_d;

    logic    last_slot;
    logic    accept;
    logic    start;
    logic    rd_en;
    stereo_t wr_data;
    stereo_t rd_data;

    assign wr_data = '{lft: lft_in, rght: rght_in};

    // The exit cycle of SEQ accepts a sample so back-to-back bursts lose nothing.
    assign last_slot = (state_q == ST_SEQ) && (slot_q == LAST_SLOT);
    assign accept    = valid && ((state_q == ST_IDLE) || last_slot);
    assign wr_ptr_d  = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign fill_d    = (accept && (fill_q != TAPS_F)) ? fill_q + FW'(1) : fill_q;
    assign start     = accept && (fill_d == TAPS_F);

    // No read on the exit cycle: that address may be the one being written.
    assign rd_en = (state_q == ST_PRIME) || ((state_q == ST_SEQ) && !last_slot);

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        slot_d   = slot_q;
        seq_d    = 1'b0;
        out_d    = out_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_PRIME;
                    rd_ptr_d = wr_ptr_d - TAPS_A;
                end
            end
            ST_PRIME: begin
                state_d  = ST_SEQ;
                rd_ptr_d = rd_ptr_q + AW'(1);
                slot_d   = '0;
            end
            ST_SEQ: begin
                seq_d  = 1'b1;
                out_d  = rd_data;
                slot_d = slot_q + CW'(1);
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
                if (last_slot) begin
                    if (start) begin
                        state_d  = ST_PRIME;
                        rd_ptr_d = wr_ptr_d - TAPS_A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            slot_q   <= '0;
            seq_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            slot_q   <= slot_d;
            seq_q    <= seq_d;
            out_q    <= out_d;
        end
    end

    queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign sequencing = seq_q;
    assign lft_out    = out_q.lft;
    assign rght_out   = out_q.rght;

`ifdef OVERRUN_DET_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (valid && !accept) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_sample_seq_queue.sv
// Scoreboard bench for sample_seq_queue: a small DEPTH=8/TAPS=5 instance plus a default-parameter one.
module tb_sample_seq_queue;
    import filt_pkg::*;

    localparam int unsigned S_DEPTH = 8;
    localparam int unsigned S_TAPS  = 5;
    localparam int unsigned B_TAPS  = TAPS_DEF;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    s_valid, b_valid;
    sample_t s_lft, s_rght, b_lft, b_rght;
    logic    s_seq, b_seq;
    sample_t s_lo, s_ro, b_lo, b_ro;
`ifdef OVERRUN_DET_EN
    logic    s_ovr, b_ovr;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    stereo_t s_exp[$];
    stereo_t b_exp[$];
    int      s_hist[$];
    int      s_run = 0;
    int      b_run = 0;

    always #5 clk = ~clk;

    sample_seq_queue #(
        .DEPTH (S_DEPTH),
        .TAPS  (S_TAPS)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (s_valid),
        .lft_in     (s_lft),
        .rght_in    (s_rght),
        .sequencing (s_seq),
        .lft_out    (s_lo),
        .rght_out   (s_ro)
`ifdef OVERRUN_DET_EN
        ,
        .overrun    (s_ovr)
`endif
    );

    sample_seq_queue u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (b_valid),
        .lft_in     (b_lft),
        .rght_in    (b_rght),
        .sequencing (b_seq),
        .lft_out    (b_lo),
        .rght_out   (b_ro)
`ifdef OVERRUN_DET_EN
        ,
        .overrun    (b_ovr)
`endif
    );

    task automatic check(input string name, input int act, input int req);
        vec_cnt++;
        if (act != req) begin
            err_cnt++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Drives one sample starting just after a rising edge; returns just after the accepting edge.
    task automatic send_s(input int v, input bit acc);
        s_valid = 1'b1;
        s_lft   = sample_t'(v);
        s_rght  = sample_t'(-v);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        if (acc) begin
            s_hist.push_back(v);
            if (s_hist.size() > S_TAPS) void'(s_hist.pop_front());
            if (s_hist.size() == S_TAPS) begin
                foreach (s_hist[i]) s_exp.push_back('{lft: sample_t'(s_hist[i]),
                                                      rght: sample_t'(-s_hist[i])});
            end
        end
    endtask

    task automatic send_b(input int v);
        b_valid = 1'b1;
        b_lft   = sample_t'(v);
        b_rght  = sample_t'(-v);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: pop one expected pair per sequencing cycle and check burst length on the fall.
    initial begin
        stereo_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_run = 0;
            end else if (s_seq) begin
                s_run++;
                if (s_exp.size() == 0) begin
                    check("s_unexpected_slot", 1, 0);
                end else begin
                    e = s_exp.pop_front();
                    check("s_lft_out", s_lo, e.lft);
                    check("s_rght_out", s_ro, e.rght);
                end
            end else begin
                if (s_run != 0) check("s_burst_len", s_run, S_TAPS);
                s_run = 0;
            end
        end
    end

    initial begin
        stereo_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_run = 0;
            end else if (b_seq) begin
                b_run++;
                if (b_exp.size() == 0) begin
                    check("b_unexpected_slot", 1, 0);
                end else begin
                    e = b_exp.pop_front();
                    check("b_lft_out", b_lo, e.lft);
                    check("b_rght_out", b_ro, e.rght);
                end
            end else begin
                if (b_run != 0) check("b_burst_len", b_run, B_TAPS);
                b_run = 0;
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        b_valid = 1'b0;
        s_lft   = '0;
        s_rght  = '0;
        b_lft   = '0;
        b_rght  = '0;
        idle(3);
        check("reset_seq", s_seq, 0);
        check("reset_lft", s_lo, 0);
        check("reset_rght", s_ro, 0);
`ifdef OVERRUN_DET_EN
        check("reset_overrun", s_ovr, 0);
`endif
        rst_n = 1'b1;
        idle(1);

        // Fill: four samples, no burst yet.
        for (int v = 1; v <= 4; v++) send_s(v, 1'b1);
        idle(4);
        check("fill_seq_low", s_seq, 0);
        check("fill_cnt", int'(u_small.fill_q), 4);

        // First burst: two-cycle latency from the accepting edge.
        send_s(5, 1'b1);
        @(negedge clk);
        check("latency_n", s_seq, 0);
        @(negedge clk);
        check("latency_n1", s_seq, 0);
        @(negedge clk);
        check("latency_n2", s_seq, 1);
        idle(S_TAPS + 3);

        // Pointer wrap: burst for 11 spans addresses 6,7,0,1,2.
        for (int v = 6; v <= 11; v++) begin
            send_s(v, 1'b1);
            idle(S_TAPS + 3);
        end

        // Overrun: sample during SEQ is dropped.
        send_s(12, 1'b1);
        idle(2);
        send_s(99, 1'b0);
`ifdef OVERRUN_DET_EN
        check("overrun_set", s_ovr, 1);
`endif
        idle(S_TAPS + 3);
        check("idle_after_overrun", s_seq, 0);

        // Drop one cycle before exit, accept on the exit cycle itself.
        send_s(13, 1'b1);
        idle(S_TAPS - 1);
        send_s(98, 1'b0);
        send_s(14, 1'b1);
`ifdef OVERRUN_DET_EN
        check("overrun_sticky", s_ovr, 1);
`endif
        idle(2 * S_TAPS + 6);

        // Reset in the middle of a burst, while slot 2 is presented.
        send_s(15, 1'b1);
        idle(2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_seq", s_seq, 0);
        check("abort_lft", s_lo, 0);
        check("abort_rght", s_ro, 0);
`ifdef OVERRUN_DET_EN
        check("abort_overrun", s_ovr, 0);
`endif
        s_exp.delete();
        s_hist.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        for (int v = 20; v <= 23; v++) send_s(v, 1'b1);
        idle(S_TAPS + 3);
        check("refill_seq_low", s_seq, 0);
        check("refill_cnt", int'(u_small.fill_q), 4);
        send_s(24, 1'b1);
        idle(S_TAPS + 4);
        check("s_exp_drained", s_exp.size(), 0);

        // Default parameters: fill with a ramp, then one more sample.
        for (int v = 1; v <= int'(B_TAPS); v++) b_exp.push_back('{lft: sample_t'(v),
                                                                   rght: sample_t'(-v)});
        for (int v = 1; v <= int'(B_TAPS); v++) send_b(v);
        idle(B_TAPS + 4);
        check("b_first_drained", b_exp.size(), 0);
        for (int v = 2; v <= int'(B_TAPS) + 1; v++) b_exp.push_back('{lft: sample_t'(v),
                                                                       rght: sample_t'(-v)});
        send_b(int'(B_TAPS) + 1);
        idle(B_TAPS + 4);
        check("b_second_drained", b_exp.size(), 0);
        check("b_idle_seq", b_seq, 0);
        check("b_hold_lft", b_lo, int'(B_TAPS) + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
